// File: rtl/sram_fifo_pkg.sv
// Shared defaults and helpers for the SRAM-backed FIFO controller.
package sram_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int DEFAULT_NUM_WMASKS = 4;

  // Width of the occupancy counter. It covers RAM_DEPTH SRAM words,
  // one read in flight, and the two output-buffer entries.
  function automatic int level_width(input int addr_width);
    return addr_width + 2;
  endfunction

endpackage

// File: rtl/sram_fifo_obuf.sv
// Two-entry output buffer that presents the FIFO head to the pop side.
module sram_fifo_obuf
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [1:0]            count,
  output logic                  valid
);

  logic [DATA_WIDTH-1:0] slot [2];
  logic                  head;
  logic [1:0]            count_q;
  logic                  pop_en;
  logic                  wr_idx;

  assign pop_en   = pop && (count_q != 2'd0);
  // When the buffer is full, the owner pushes only in a cycle that also pops.
  // In that case the tail slot is the head slot that is being freed.
  assign wr_idx   = head ^ count_q[0];
  assign pop_data = slot[head];
  assign count    = count_q;
  assign valid    = (count_q != 2'd0);

  // Track the occupancy and the head position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head    <= 1'b0;
    end else begin
      if (push && !pop_en) begin
        count_q <= count_q + 2'd1;
      end else if (pop_en && !push) begin
        count_q <= count_q - 2'd1;
      end
      if (pop_en) begin
        head <= ~head;
      end
    end
  end

  // Payload storage. It needs no reset because validity comes from count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      slot[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller that stores words in an external 1RW+1R SRAM.
// Port 0 is used only for writes. Port 1 reads words into a 2-entry
// output buffer.
// Optional feature: define SRAM_FIFO_BYPASS_EN to let a push go straight
// into the output buffer when the SRAM and the read pipe are empty.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_WMASKS = DEFAULT_NUM_WMASKS
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 push_valid,
  output logic                                 push_ready,
  input  logic [DATA_WIDTH-1:0]                push_data,
  output logic                                 pop_valid,
  input  logic                                 pop_ready,
  output logic [DATA_WIDTH-1:0]                pop_data,
  output logic [level_width(ADDR_WIDTH)-1:0]   level,
  output logic                                 csb0,
  output logic                                 web0,
  output logic [NUM_WMASKS-1:0]                wmask0,
  output logic [ADDR_WIDTH-1:0]                addr0,
  output logic [DATA_WIDTH-1:0]                din0,
  output logic                                 csb1,
  output logic [ADDR_WIDTH-1:0]                addr1,
  input  logic [DATA_WIDTH-1:0]                dout1
);

  localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW        = ADDR_WIDTH + 1;
  localparam int LW        = level_width(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         mem_count;
  logic                  rd_inflight;
  logic [1:0]            ob_count;
  logic                  push_fire;
  logic                  pop_fire;
  logic                  bypass;
  logic                  store;
  logic                  issue;
  logic [2:0]            ob_committed;
  logic                  ob_push;
  logic [DATA_WIDTH-1:0] ob_wdata;

  assign push_ready   = rst_n && (mem_count < CW'(RAM_DEPTH));
  assign push_fire    = push_valid && push_ready;
  assign pop_fire     = pop_valid && pop_ready;
  assign ob_committed = 3'(ob_count) + 3'(rd_inflight);

`ifdef SRAM_FIFO_BYPASS_EN
  // Bypass only when nothing older is in the SRAM or the read pipe.
  // This keeps the words in order.
  assign bypass = push_fire && (mem_count == '0) && !rd_inflight &&
                  (3'(ob_count) < 3'd2 + 3'(pop_fire));
`else
  assign bypass = 1'b0;
`endif

  assign store = push_fire && !bypass;
  // Issue a read only if the returning word is sure to find a free slot.
  // A pop in the current cycle counts toward that free space.
  assign issue = (mem_count != '0) && (ob_committed < 3'd2 + 3'(pop_fire));

  assign csb0   = !store;
  assign web0   = !store;
  assign wmask0 = '1;
  assign addr0  = wr_ptr;
  assign din0   = push_data;
  assign csb1   = !issue;
  assign addr1  = rd_ptr;

  assign ob_push  = rd_inflight || bypass;
  assign ob_wdata = rd_inflight ? dout1 : push_data;

  assign level = LW'(mem_count) + LW'(rd_inflight) + LW'(ob_count);

  // Update the SRAM pointers, the resident-word count and the read-pipe flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_count   <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (issue) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      rd_inflight <= issue;
      case ({store, issue})
        2'b10:   mem_count <= mem_count + CW'(1);
        2'b01:   mem_count <= mem_count - CW'(1);
        default: mem_count <= mem_count;
      endcase
    end
  end

  sram_fifo_obuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ob_push),
    .push_data (ob_wdata),
    .pop       (pop_fire),
    .pop_data  (pop_data),
    .count     (ob_count),
    .valid     (pop_valid)
  );

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed testbench for sram_fifo_ctrl with a behavioural 1RW+1R SRAM.
module tb_sram_fifo_ctrl;

`ifdef SRAM_FIFO_BYPASS_EN
  localparam int EXP_LAT         = 1;
  localparam int EXP_WRAPS       = 0;
  localparam logic EXP_SINGLE_CS = 1'b1;
`else
  localparam int EXP_LAT         = 2;
  localparam int EXP_WRAPS       = 3;
  localparam logic EXP_SINGLE_CS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_data;
  logic        pop_valid;
  logic        pop_ready;
  logic [31:0] pop_data;
  logic [6:0]  level;
  logic        csb0;
  logic        web0;
  logic [3:0]  wmask0;
  logic [4:0]  addr0;
  logic [31:0] din0;
  logic        csb1;
  logic [4:0]  addr1;
  logic [31:0] dout1;

  logic [31:0] sram [32];

  int checks   = 0;
  int failures = 0;

  sram_fifo_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_data   (pop_data),
    .level      (level),
    .csb0       (csb0),
    .web0       (web0),
    .wmask0     (wmask0),
    .addr0      (addr0),
    .din0       (din0),
    .csb1       (csb1),
    .addr1      (addr1),
    .dout1      (dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM model with a registered read output.
  always @(posedge clk) begin
    if (!csb0 && !web0) sram[addr0] <= din0;
    if (!csb1) dout1 <= sram[addr1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    push_valid = 1'b1;
    push_data = 32'h1234_5678;
    pop_ready = 1'b1;
    tick();
    tick();
    checks++; if (push_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_push_ready got %0b expected 0", push_ready); end
    checks++; if (csb0 !== 1'b1) begin failures++; $display("[TB] FAIL reset_csb0 got %0b expected 1", csb0); end
    checks++; if (web0 !== 1'b1) begin failures++; $display("[TB] FAIL reset_web0 got %0b expected 1", web0); end
    checks++; if (csb1 !== 1'b1) begin failures++; $display("[TB] FAIL reset_csb1 got %0b expected 1", csb1); end
    checks++; if (pop_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_pop_valid got %0b expected 0", pop_valid); end
    checks++; if (level !== 7'd0) begin failures++; $display("[TB] FAIL reset_level got %0d expected 0", level); end
    push_valid = 1'b0;
    pop_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if (push_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_push_ready got %0b expected 1", push_ready); end
    checks++; if (level !== 7'd0) begin failures++; $display("[TB] FAIL post_reset_level got %0d expected 0", level); end
  endtask

  task automatic test_single();
    int lat;
    pop_ready = 1'b1;
    push_valid = 1'b1;
    push_data = 32'hA5A5_A5A5;
    #1;
    checks++; if (csb0 !== EXP_SINGLE_CS) begin failures++; $display("[TB] FAIL single_csb0 got %0b expected %0b", csb0, EXP_SINGLE_CS); end
    tick();
    push_valid = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (pop_valid !== 1'b1 && lat < 6);
    checks++; if (lat !== EXP_LAT) begin failures++; $display("[TB] FAIL single_latency got %0d expected %0d", lat, EXP_LAT); end
    checks++; if (pop_data !== 32'hA5A5_A5A5) begin failures++; $display("[TB] FAIL single_data got %h expected a5a5a5a5", pop_data); end
    tick();
    checks++; if (pop_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_drained_valid got %0b expected 0", pop_valid); end
    checks++; if (level !== 7'd0) begin failures++; $display("[TB] FAIL single_level got %0d expected 0", level); end
    pop_ready = 1'b0;
  endtask

  task automatic test_fill();
    int got;
    int cyc;
    pop_ready = 1'b0;
    for (int i = 0; i < 34; i++) begin
      push_valid = 1'b1;
      push_data = 32'h1000_0000 + i;
      #1;
      checks++; if (push_ready !== 1'b1) begin failures++; $display("[TB] FAIL fill_push_ready word %0d got %0b expected 1", i, push_ready); end
      if (i == 10) begin
        checks++; if (csb0 !== 1'b0) begin failures++; $display("[TB] FAIL fill_csb0_write got %0b expected 0", csb0); end
        checks++; if (wmask0 !== 4'hF) begin failures++; $display("[TB] FAIL fill_wmask0 got %h expected f", wmask0); end
      end
      tick();
    end
    checks++; if (push_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_push_ready got %0b expected 0", push_ready); end
    checks++; if (level !== 7'd34) begin failures++; $display("[TB] FAIL full_level got %0d expected 34", level); end
    push_data = 32'h0BAD_0BAD;
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1;
      #1;
      checks++; if (csb0 !== 1'b1) begin failures++; $display("[TB] FAIL full_csb0 cycle %0d got %0b expected 1", i, csb0); end
      tick();
    end
    push_valid = 1'b0;
    checks++; if (level !== 7'd34) begin failures++; $display("[TB] FAIL full_level_hold got %0d expected 34", level); end
    pop_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 34 && cyc < 200) begin
      if (pop_valid === 1'b1) begin
        checks++; if (pop_data !== 32'h1000_0000 + got) begin failures++; $display("[TB] FAIL fill_drain_data idx %0d got %h expected %h", got, pop_data, 32'h1000_0000 + got); end
        got++;
      end
      tick();
      cyc++;
    end
    pop_ready = 1'b0;
    checks++; if (got !== 34) begin failures++; $display("[TB] FAIL fill_drain_count got %0d expected 34", got); end
    checks++; if (level !== 7'd0) begin failures++; $display("[TB] FAIL fill_drain_level got %0d expected 0", level); end
  endtask

  task automatic test_stream();
    int sent, got, cyc, first, last, wraps, prev;
    logic fired;
    sent = 0; got = 0; cyc = 0; first = -1; last = -1; wraps = 0; prev = -1;
    pop_ready = 1'b1;
    while (got < 100 && cyc < 500) begin
      push_valid = (sent < 100);
      push_data = 32'h2000_0000 + sent;
      #1;
      if (csb0 === 1'b0) begin
        if (prev == 31 && addr0 == 5'd0) wraps++;
        prev = int'(addr0);
      end
      fired = push_valid && push_ready;
      if (pop_valid === 1'b1) begin
        checks++; if (pop_data !== 32'h2000_0000 + got) begin failures++; $display("[TB] FAIL stream_data idx %0d got %h expected %h", got, pop_data, 32'h2000_0000 + got); end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      tick();
      if (fired) sent++;
      cyc++;
    end
    push_valid = 1'b0;
    pop_ready = 1'b0;
    checks++; if (got !== 100) begin failures++; $display("[TB] FAIL stream_count got %0d expected 100", got); end
    checks++; if (last - first !== 99) begin failures++; $display("[TB] FAIL stream_gapless got span %0d expected 99", last - first); end
    checks++; if (wraps !== EXP_WRAPS) begin failures++; $display("[TB] FAIL stream_wraps got %0d expected %0d", wraps, EXP_WRAPS); end
  endtask

  task automatic test_toggle();
    int sent, got, cyc, viol, net;
    logic fired, popf;
    sent = 0; got = 0; cyc = 0; viol = 0;
    while (got < 60 && cyc < 800) begin
      push_valid = (sent < 60);
      push_data = 32'h3000_0000 + sent;
      pop_ready = cyc[0];
      #1;
      popf = (pop_valid === 1'b1) && pop_ready;
      net = int'(dut.ob_count) + int'(dut.rd_inflight) - int'(popf);
      if (csb1 === 1'b0 && net >= 2) viol++;
      fired = push_valid && push_ready;
      if (popf) begin
        checks++; if (pop_data !== 32'h3000_0000 + got) begin failures++; $display("[TB] FAIL toggle_data idx %0d got %h expected %h", got, pop_data, 32'h3000_0000 + got); end
        got++;
      end
      tick();
      if (fired) sent++;
      cyc++;
    end
    push_valid = 1'b0;
    pop_ready = 1'b0;
    checks++; if (got !== 60) begin failures++; $display("[TB] FAIL toggle_count got %0d expected 60", got); end
    checks++; if (viol !== 0) begin failures++; $display("[TB] FAIL toggle_overissue got %0d expected 0", viol); end
    checks++; if (level !== 7'd0) begin failures++; $display("[TB] FAIL toggle_level got %0d expected 0", level); end
  endtask

  task automatic test_reset_inflight();
    int lat;
    pop_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      push_valid = 1'b1;
      push_data = 32'h4000_0000 + i;
      tick();
    end
    push_valid = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (level !== 7'd11) begin failures++; $display("[TB] FAIL inflight_pre_level got %0d expected 11", level); end
    pop_ready = 1'b1;
    #1;
    checks++; if (csb1 !== 1'b0) begin failures++; $display("[TB] FAIL inflight_issue got %0b expected 0", csb1); end
    tick();
    pop_ready = 1'b0;
    checks++; if (level !== 7'd10) begin failures++; $display("[TB] FAIL inflight_level got %0d expected 10", level); end
    rst_n = 1'b0;
    #1;
    checks++; if (level !== 7'd0) begin failures++; $display("[TB] FAIL inflight_reset_level got %0d expected 0", level); end
    checks++; if (pop_valid !== 1'b0) begin failures++; $display("[TB] FAIL inflight_reset_valid got %0b expected 0", pop_valid); end
    checks++; if (push_ready !== 1'b0) begin failures++; $display("[TB] FAIL inflight_reset_ready got %0b expected 0", push_ready); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    pop_ready = 1'b1;
    push_valid = 1'b1;
    push_data = 32'hDEAD_0001;
    tick();
    push_valid = 1'b0;
    lat = 0;
    while (pop_valid !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    checks++; if (pop_valid !== 1'b1) begin failures++; $display("[TB] FAIL after_reset_valid got %0b expected 1", pop_valid); end
    checks++; if (pop_data !== 32'hDEAD_0001) begin failures++; $display("[TB] FAIL after_reset_first got %h expected dead0001", pop_data); end
    tick();
    pop_ready = 1'b0;
    checks++; if (level !== 7'd0) begin failures++; $display("[TB] FAIL after_reset_level got %0d expected 0", level); end
  endtask

  initial begin
    rst_n = 1'b0;
    push_valid = 1'b0;
    push_data = '0;
    pop_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    pulse_reset();
    test_stream();
    test_toggle();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
